// File: rtl/axi_rd_ocp_bridge_if.sv
// AXI read-channel (AR/R) and OCP master bundle for axi_rd_ocp_bridge.
// The slave modport is the bridge's view; master is the surrounding environment's view.
interface axi_rd_ocp_bridge_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [3:0]    ARID;
  logic [AW-1:0] ARADDR;
  logic [3:0]    ARLEN;
  logic [2:0]    ARSIZE;
  logic [1:0]    ARBURST;
  logic [1:0]    ARLOCK;
  logic [3:0]    ARCACHE;
  logic [2:0]    ARPROT;
  logic          ARVALID;
  logic          ARREADY;
  logic [3:0]    RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY;
  logic [2:0]    MTagID;
  logic [AW-1:0] MAddr;
  logic [2:0]    MCmd;
  logic [DW-1:0] Mdata;
  logic          MDataValid;
  logic          MRespAccept;
  logic          SCmdAccept;
  logic [DW-1:0] Sdata;
  logic          SDataAccept;
  logic [1:0]    SResp;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    output MTagID, MAddr, MCmd, Mdata, MDataValid, MRespAccept,
    input  SCmdAccept, Sdata, SDataAccept, SResp
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    input  MTagID, MAddr, MCmd, Mdata, MDataValid, MRespAccept,
    output SCmdAccept, Sdata, SDataAccept, SResp
  );
endinterface

// File: rtl/axi_rd_ocp_bridge.sv
// AXI read slave to OCP read master bridge: one burst at a time, one OCP read per beat,
// in-order response FIFO. Define AXI_OCP_RD_ERR_CNT_EN to add the saturating err_cnt output.
module axi_rd_ocp_bridge #(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned RD_FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  axi_rd_ocp_bridge_if.slave bus
`ifdef AXI_OCP_RD_ERR_CNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);
  localparam int unsigned PtrW    = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned LdW     = PtrW + 2;
  localparam int unsigned MaxSize = $clog2(DW / 8);
  localparam logic [2:0]  CmdIdle = 3'b000;
  localparam logic [2:0]  CmdRead = 3'b010;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StErrb} state_e;

  state_e              state_q;
  logic                arready_q, resp_acc_q;
  logic [3:0]          id_q, len_q, cmd_cnt_q, r_cnt_q;
  logic [2:0]          size_q, mcmd_q;
  logic [1:0]          burst_q;
  logic [AW-1:0]       addr_q, addr_nxt, incr, wrap_mask;
  logic [CntW-1:0]     fifo_cnt_q, fifo_cnt_d, out_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [DW-1:0]       fifo_data_q [RD_FIFO_DEPTH];
  logic [RD_FIFO_DEPTH-1:0] fifo_err_q;
  logic                ar_bad, cmd_acc, push, pop, rvalid, rlast, r_fire, credit_nxt;
  logic [1:0]          rresp;
  logic [LdW-1:0]      load_nxt;
  logic                unused_inputs;

  assign unused_inputs = ^{bus.ARLOCK, bus.ARCACHE, bus.ARPROT, bus.SDataAccept};

  assign ar_bad  = (32'(bus.ARSIZE) > MaxSize) || (bus.ARBURST == 2'b11);
  assign cmd_acc = (mcmd_q == CmdRead) && bus.SCmdAccept;
  assign push    = resp_acc_q && (bus.SResp != 2'b00);
  assign rvalid  = (state_q == StErrb) || (fifo_cnt_q != '0);
  assign rlast   = rvalid && (r_cnt_q == len_q);
  assign r_fire  = rvalid && bus.RREADY;
  assign pop     = r_fire && (state_q != StErrb);
  assign rresp   = (rvalid && ((state_q == StErrb) || fifo_err_q[rd_ptr_q])) ? 2'b10 : 2'b00;

  assign fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
  // Credit looks at post-edge occupancy so a registered MCmd never overcommits the FIFO.
  assign load_nxt   = LdW'(out_q) + LdW'(fifo_cnt_q) + LdW'(cmd_acc) - LdW'(pop);
  assign credit_nxt = load_nxt < LdW'(RD_FIFO_DEPTH);

  assign incr      = AW'(1) << size_q;
  assign wrap_mask = (AW'({1'b0, len_q} + 5'd1) << size_q) - AW'(1);

  always_comb begin
    addr_nxt = addr_q + incr;
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
      default: addr_nxt = addr_q + incr;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      arready_q <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      addr_q    <= '0;
      mcmd_q    <= CmdIdle;
      cmd_cnt_q <= '0;
      r_cnt_q   <= '0;
    end else begin
      if (r_fire) r_cnt_q <= r_cnt_q + 4'd1;
      unique case (state_q)
        StIdle: begin
          arready_q <= 1'b1;
          if (bus.ARVALID && arready_q) begin
            arready_q <= 1'b0;
            id_q      <= bus.ARID;
            addr_q    <= bus.ARADDR;
            len_q     <= bus.ARLEN;
            size_q    <= bus.ARSIZE;
            burst_q   <= bus.ARBURST;
            cmd_cnt_q <= '0;
            r_cnt_q   <= '0;
            if (ar_bad) begin
              state_q <= StErrb;
            end else begin
              state_q <= StIssue;
              mcmd_q  <= CmdRead;
            end
          end
        end
        StIssue: begin
          if (cmd_acc) begin
            cmd_cnt_q <= cmd_cnt_q + 4'd1;
            if (cmd_cnt_q == len_q) begin
              mcmd_q  <= CmdIdle;
              state_q <= StDrain;
            end else begin
              addr_q <= addr_nxt;
              mcmd_q <= credit_nxt ? CmdRead : CmdIdle;
            end
          end else if (mcmd_q != CmdRead && credit_nxt) begin
            mcmd_q <= CmdRead;
          end
        end
        StDrain, StErrb: begin
          if (r_fire && rlast) begin
            state_q   <= StIdle;
            arready_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_cnt_q  <= '0;
      out_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      resp_acc_q  <= 1'b0;
      fifo_data_q <= '{default: '0};
      fifo_err_q  <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      out_q      <= out_q + CntW'(cmd_acc) - CntW'(push);
      resp_acc_q <= (fifo_cnt_d != CntW'(RD_FIFO_DEPTH));
      if (push) begin
        fifo_data_q[wr_ptr_q] <= bus.Sdata;
        fifo_err_q[wr_ptr_q]  <= bus.SResp[1];
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  assign bus.ARREADY     = arready_q;
  assign bus.RID         = id_q;
  assign bus.RDATA       = (state_q == StErrb) ? '0 : fifo_data_q[rd_ptr_q];
  assign bus.RRESP       = rresp;
  assign bus.RLAST       = rlast;
  assign bus.RVALID      = rvalid;
  assign bus.MTagID      = id_q[2:0];
  assign bus.MAddr       = addr_q;
  assign bus.MCmd        = mcmd_q;
  assign bus.Mdata       = '0;
  assign bus.MDataValid  = 1'b0;
  assign bus.MRespAccept = resp_acc_q;

`ifdef AXI_OCP_RD_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else if (r_fire && rresp[1] && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
  assign err_cnt = err_cnt_q;
`endif
endmodule
